// File: rtl/harmonic_param_ctrl.sv
// Shadow/active parameter bank between the ADC frame receiver and the harmonic datapath.
// Optional macro FREQ_SLEW_EN limits the o_Frequency change per commit to MAX_FREQ_STEP.
module harmonic_param_ctrl #(
  parameter int          DIV_BIT           = 11,
  parameter logic [7:0]  MAX_HARMONICS     = 8'd100,
  parameter logic [15:0] DEFAULT_FREQUENCY = 16'd90,
  parameter logic [15:0] MAX_FREQ_STEP     = 16'd256
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Data_Received,
  input  logic [15:0]        i_Data0,
  input  logic [15:0]        i_Data1,
  input  logic [15:0]        i_Data2,
  input  logic [15:0]        i_Data3,
  input  logic [15:0]        i_Data4,
  input  logic [15:0]        i_Data5,
  input  logic [15:0]        i_Data6,
  input  logic               i_Frame_Start,
  output logic [15:0]        o_Frequency,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale0,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale1,
  output logic [DIV_BIT-1:0] o_Scale_Initial0,
  output logic [DIV_BIT-1:0] o_Scale_Initial1,
  output logic [15:0]        o_Freq_Scale,
  output logic [7:0]         o_Harmonic_Count,
  output logic               o_Params_Valid,
  output logic               o_Update_Pending,
  output logic               o_Overrun
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_PENDING, S_APPLY} state_t;

  state_t r_state;
  state_t w_next_state;

  logic               r_data_prev;
  logic               r_edge_flag;
  logic [15:0]        r_sh_freq;
  logic [DIV_BIT-1:0] r_sh_scale0;
  logic [DIV_BIT-1:0] r_sh_init0;
  logic [DIV_BIT-1:0] r_sh_scale1;
  logic [DIV_BIT-1:0] r_sh_init1;
  logic [15:0]        r_sh_fofs;
  logic [7:0]         r_sh_count;

  logic [15:0]        r_freq;
  logic [DIV_BIT-1:0] r_scale0;
  logic [DIV_BIT-1:0] r_scale1;
  logic [DIV_BIT-1:0] r_init0;
  logic [DIV_BIT-1:0] r_init1;
  logic [15:0]        r_fofs;
  logic [7:0]         r_count;
  logic               r_valid;
  logic               r_pending;
  logic               r_overrun;

  logic               w_edge;
  logic               w_flag_next;
  logic               w_overrun;
  logic [15:0]        w_freq_next;
  logic               w_freq_done;
  logic [7:0]         w_count_clamped;

  assign w_edge          = i_Data_Received & ~r_data_prev;
  assign w_count_clamped = (r_sh_count > MAX_HARMONICS) ? MAX_HARMONICS : r_sh_count;
  assign w_freq_done     = (w_freq_next == r_sh_freq);

  // Frequency target for this commit; with slewing it may stop short of the shadow value.
  always_comb begin
    w_freq_next = r_sh_freq;
`ifdef FREQ_SLEW_EN
    if ((r_sh_freq > r_freq) && ((r_sh_freq - r_freq) > MAX_FREQ_STEP))
      w_freq_next = r_freq + MAX_FREQ_STEP;
    else if ((r_freq > r_sh_freq) && ((r_freq - r_sh_freq) > MAX_FREQ_STEP))
      w_freq_next = r_freq - MAX_FREQ_STEP;
`endif
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_edge | r_edge_flag) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_PENDING;
      S_PENDING: begin
        if (i_Frame_Start)              w_next_state = S_APPLY;
        else if (w_edge | r_edge_flag)  w_next_state = S_CAPTURE;
      end
      S_APPLY: begin
        if (!w_freq_done)               w_next_state = S_PENDING;
        else if (w_edge | r_edge_flag)  w_next_state = S_CAPTURE;
        else                            w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Edges that cannot be serviced immediately park in r_edge_flag; a second one is an overrun.
  always_comb begin
    w_flag_next = r_edge_flag;
    w_overrun   = 1'b0;
    case (r_state)
      S_IDLE: w_flag_next = 1'b0;
      S_CAPTURE: begin
        if (w_edge) begin
          w_overrun   = r_edge_flag;
          w_flag_next = 1'b1;
        end
      end
      S_PENDING: begin
        if (i_Frame_Start) begin
          if (w_edge) begin
            w_overrun   = r_edge_flag;
            w_flag_next = 1'b1;
          end
        end else if (w_edge | r_edge_flag) begin
          w_overrun   = 1'b1;
          w_flag_next = 1'b0;
        end
      end
      S_APPLY: begin
        if (w_edge) w_overrun = r_edge_flag;
        w_flag_next = w_freq_done ? 1'b0 : (r_edge_flag | w_edge);
      end
      default: w_flag_next = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_data_prev <= i_Data_Received;
      r_edge_flag <= 1'b0;
      r_sh_freq   <= '0;
      r_sh_scale0 <= '0;
      r_sh_init0  <= '0;
      r_sh_scale1 <= '0;
      r_sh_init1  <= '0;
      r_sh_fofs   <= '0;
      r_sh_count  <= '0;
      r_freq      <= DEFAULT_FREQUENCY;
      r_scale0    <= '0;
      r_scale1    <= '0;
      r_init0     <= '0;
      r_init1     <= '0;
      r_fofs      <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_data_prev <= i_Data_Received;
      r_edge_flag <= w_flag_next;
      r_overrun   <= w_overrun;
      r_pending   <= (w_next_state == S_PENDING) || (w_next_state == S_APPLY);
      if (r_state == S_CAPTURE) begin
        r_sh_freq   <= i_Data0;
        r_sh_scale0 <= i_Data1[DIV_BIT-1:0];
        r_sh_init0  <= i_Data2[DIV_BIT-1:0];
        r_sh_scale1 <= i_Data3[DIV_BIT-1:0];
        r_sh_init1  <= i_Data4[DIV_BIT-1:0];
        r_sh_fofs   <= i_Data5;
        r_sh_count  <= i_Data6[7:0];
      end
      if (r_state == S_APPLY) begin
        r_freq   <= w_freq_next;
        r_scale0 <= r_sh_scale0;
        r_init0  <= r_sh_init0;
        r_scale1 <= r_sh_scale1;
        r_init1  <= r_sh_init1;
        r_fofs   <= r_sh_fofs;
        r_count  <= w_count_clamped;
        r_valid  <= 1'b1;
      end
    end
  end

  assign o_Frequency       = r_freq;
  assign o_Harmonic_Scale0 = r_scale0;
  assign o_Harmonic_Scale1 = r_scale1;
  assign o_Scale_Initial0  = r_init0;
  assign o_Scale_Initial1  = r_init1;
  assign o_Freq_Scale      = r_fofs;
  assign o_Harmonic_Count  = r_count;
  assign o_Params_Valid    = r_valid;
  assign o_Update_Pending  = r_pending;
  assign o_Overrun         = r_overrun;

endmodule
